// File: rtl/uart_tx_framer.sv
// UART transmitter: serialises a latched word as start, LSB-first data,
// optional parity and stop bit(s), with bit timing from an internal counter.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] dIn,
  output logic                 txOut,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cyc_reg, cyc_next;
  logic [2:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 cyc_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cyc_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cyc_next    = cyc_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    done_next   = 1'b0;
    cyc_end     = (cyc_reg == CYC_LAST);

    // The cycle counter only advances inside a frame and wraps at each bit end.
    if (state_reg != IDLE) begin
      cyc_next = cyc_end ? '0 : cyc_reg + CW'(1);
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = START;
          shift_next  = dIn;
          parity_next = (^dIn) ^ 1'(PARITY_ODD);
          cyc_next    = '0;
          bit_next    = '0;
        end
      end
      START: begin
        if (cyc_end) state_next = DATA;
      end
      DATA: begin
        if (cyc_end) begin
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (cyc_end) state_next = STOP;
      end
      STOP: begin
        if (cyc_end) begin
          if (bit_reg == STOP_LAST) begin
            bit_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the upcoming state so it changes with the state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign txOut = tx_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four configurations share stimulus and are checked
// every cycle against an expected-waveform model, plus directed frame vectors.
module tb_uart_tx_framer;

  localparam int C = 4;
  localparam int CD [4] = '{8, 8, 8, 7};
  localparam int CP [4] = '{0, 1, 1, 0};
  localparam int CO [4] = '{0, 0, 1, 0};
  localparam int CS [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dIn;
  logic       tx [4];
  logic       busy [4];
  logic       done [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .dIn(dIn), .txOut(tx[0]), .busy(busy[0]), .done(done[0]));
  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .dIn(dIn), .txOut(tx[1]), .busy(busy[1]), .done(done[1]));
  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .start(start), .dIn(dIn), .txOut(tx[2]), .busy(busy[2]), .done(done[2]));
  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .start(start), .dIn(dIn[6:0]), .txOut(tx[3]), .busy(busy[3]), .done(done[3]));

  // Reference model: on acceptance the whole expected line waveform is laid out.
  logic fr [4][0:63];
  int   flen [4];
  int   fpos [4];
  logic exp_tx [4];
  logic exp_busy [4];
  logic exp_done [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_frame(input int i, input logic [7:0] d);
    int ones;
    logic slot [0:11];
    int ns;
    ones = 0;
    ns = 0;
    slot[ns] = 1'b0; ns++;
    for (int j = 0; j < CD[i]; j++) begin
      slot[ns] = d[j]; ns++;
      if (d[j]) ones++;
    end
    if (CP[i] != 0) begin
      slot[ns] = ((ones % 2) == 1) ^ (CO[i] != 0); ns++;
    end
    for (int s = 0; s < CS[i]; s++) begin
      slot[ns] = 1'b1; ns++;
    end
    flen[i] = 0;
    for (int b = 0; b < ns; b++)
      for (int c = 0; c < C; c++) begin
        fr[i][flen[i]] = slot[b];
        flen[i]++;
      end
  endtask

  task automatic model_step();
    logic prev;
    for (int i = 0; i < 4; i++) begin
      prev = exp_busy[i];
      if (reset) begin
        flen[i] = 0; fpos[i] = 0;
        exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
      end else if (!prev && start) begin
        build_frame(i, dIn);
        exp_tx[i] = fr[i][0]; exp_busy[i] = 1'b1; exp_done[i] = 1'b0;
        fpos[i] = 1;
      end else if (prev && fpos[i] < flen[i]) begin
        exp_tx[i] = fr[i][fpos[i]]; exp_busy[i] = 1'b1; exp_done[i] = 1'b0;
        fpos[i]++;
      end else begin
        exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = prev;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("model_inst%0d {tx,busy,done}", i),
          {29'd0, tx[i], busy[i], done[i]}, {29'd0, exp_tx[i], exp_busy[i], exp_done[i]});
  endtask

  typedef struct {
    logic [7:0] din;
    int         inst;
    int         inj_k;
    logic [7:0] inj_d;
    bit         b2b;
    int         exp_blen;
    int         exp_dones;
    int         exp_gap;
    logic [7:0] exp_data;
    logic       exp_par;
  } vec_t;

  task automatic run_frame(input logic [7:0] d, input int inst, input int inj_k, input logic [7:0] inj_d,
                           input bit b2b, output int blen, output int dones, output int gap,
                           output logic [7:0] data, output logic stbit, output logic stopok, output logic par);
    int first, last, f;
    logic samp [0:127];
    blen = 0; dones = 0; first = -1; last = -1;
    for (int k = 0; k < 128; k++) samp[k] = 1'b1;
    start = 1'b1; dIn = d;
    cycle();
    for (int k = 0; k < 100; k++) begin
      if (busy[inst]) begin
        blen++; samp[k] = tx[inst];
        if (first < 0) first = k;
        last = k;
      end
      if (done[inst]) dones++;
      start = 1'b0;
      if (k == inj_k) begin start = 1'b1; dIn = inj_d; end
      if (b2b && done[inst] && dones == 1) begin start = 1'b1; dIn = inj_d; end
      cycle();
    end
    start = 1'b0;
    gap = (first < 0) ? 0 : (last - first + 1 - blen);
    f = (first < 0) ? 0 : first;
    data = 8'h00;
    for (int j = 0; j < CD[inst]; j++) data[j] = samp[f + C * (1 + j) + 1];
    stbit = samp[f + 1];
    par = samp[f + C * (1 + CD[inst]) + 1];
    stopok = 1'b1;
    for (int s = 0; s < CS[inst]; s++) stopok &= samp[f + C * (1 + CD[inst] + CP[inst] + s) + 1];
    $display("txn inst=%0d din=%h busy_cycles=%0d dones=%0d line_data=%h", inst, d, blen, dones, data);
  endtask

  vec_t vecs [7];

  initial begin
    int blen, dones, gap;
    logic [7:0] data;
    logic stbit, stopok, par;

    vecs[0] = '{8'hA5, 0, -1, 8'h00, 1'b0, 40, 1, 0, 8'hA5, 1'b0};
    vecs[1] = '{8'hA5, 1, -1, 8'h00, 1'b0, 44, 1, 0, 8'hA5, 1'b0};
    vecs[2] = '{8'hA5, 2, -1, 8'h00, 1'b0, 44, 1, 0, 8'hA5, 1'b1};
    vecs[3] = '{8'h01, 1, -1, 8'h00, 1'b0, 44, 1, 0, 8'h01, 1'b1};
    vecs[4] = '{8'h41, 3, -1, 8'h00, 1'b0, 40, 1, 0, 8'h41, 1'b0};
    vecs[5] = '{8'h3C, 0, -1, 8'hC3, 1'b1, 80, 2, 1, 8'h3C, 1'b0};
    vecs[6] = '{8'hFF, 0, 10, 8'h55, 1'b0, 40, 1, 0, 8'hFF, 1'b0};

    reset = 1'b1; start = 1'b0; dIn = 8'h00;
    for (int i = 0; i < 4; i++) begin
      flen[i] = 0; fpos[i] = 0; exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
    end
    cycle();
    start = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_tx%0d", i), {31'd0, tx[i]}, 32'd1);
      chk($sformatf("reset_busy%0d", i), {31'd0, busy[i]}, 32'd0);
      chk($sformatf("reset_done%0d", i), {31'd0, done[i]}, 32'd0);
    end
    reset = 1'b0; start = 1'b0;
    cycle();

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].din, vecs[v].inst, vecs[v].inj_k, vecs[v].inj_d, vecs[v].b2b,
                blen, dones, gap, data, stbit, stopok, par);
      chk($sformatf("vec%0d_busy_len", v), blen, vecs[v].exp_blen);
      chk($sformatf("vec%0d_dones", v), dones, vecs[v].exp_dones);
      chk($sformatf("vec%0d_gap", v), gap, vecs[v].exp_gap);
      chk($sformatf("vec%0d_data", v), {24'd0, data}, {24'd0, vecs[v].exp_data});
      chk($sformatf("vec%0d_start_bit", v), {31'd0, stbit}, 32'd0);
      chk($sformatf("vec%0d_stop_bits", v), {31'd0, stopok}, 32'd1);
      if (CP[vecs[v].inst] != 0)
        chk($sformatf("vec%0d_parity", v), {31'd0, par}, {31'd0, vecs[v].exp_par});
    end

    // Reset on the 17th cycle of a frame, with start raised on the same edge.
    start = 1'b1; dIn = 8'h00;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 16; k++) cycle();
    reset = 1'b1; start = 1'b1;
    cycle();
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("abort_inst%0d {tx,busy,done}", i), {29'd0, tx[i], busy[i], done[i]}, {29'd0, 3'b100});
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("abort_stays_idle", {31'd0, busy[0]}, 32'd0);
    end
    run_frame(8'h5A, 0, -1, 8'h00, 1'b0, blen, dones, gap, data, stbit, stopok, par);
    chk("after_abort_busy_len", blen, 40);
    chk("after_abort_data", {24'd0, data}, {24'd0, 8'h5A});
    chk("after_abort_dones", dones, 1);

    // Random traffic with occasional reset, checked by the model every cycle.
    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(0, 7) == 0);
      dIn = 8'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      if (start && !reset && !busy[0] && !done[0])
        $display("txn random inst=0 din=%h", dIn);
      cycle();
    end
    reset = 1'b0; start = 1'b0;
    for (int k = 0; k < 60; k++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
